// File: rtl/mbc_pkg.sv
// Shared types and helpers for the MBC memory-cycle scheduler.
package mbc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_WAIT_ACK,
        ST_DATA,
        ST_DONE
    } mbc_cyc_state_t;

    localparam int RQ_CHAN = 0;
    localparam int RQ_WB   = 1;
    localparam int RQ_EBOX = 2;
    localparam int NUM_RQ  = 3;

    // Next set mask bit strictly after adr, wrapping 3->0; adr itself is the
    // last candidate. With an empty mask the address is returned unchanged.
    function automatic logic [1:0] next_word(input logic [3:0] mask, input logic [1:0] adr);
        logic [1:0] cand;
        logic [1:0] result;
        result = adr;
        for (int i = 4; i >= 1; i--) begin
            cand = adr + 2'(i);
            if (mask[cand]) begin
                result = cand;
            end
        end
        return result;
    endfunction

    // Number of words requested in a quad mask.
    function automatic logic [2:0] bit_count(input logic [3:0] mask);
        logic [2:0] n;
        n = '0;
        for (int i = 0; i < 4; i++) begin
            n = n + {2'b00, mask[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/mbc_rq_prio.sv
// Fixed-priority encoder for the three core-memory requesters (chan > wb > ebox).
module mbc_rq_prio
    import mbc_pkg::*;
(
    input  logic [NUM_RQ-1:0] rq,
    output logic [NUM_RQ-1:0] gnt,
    output logic              vld
);

    // One-hot pick of the highest-priority active request.
    always_comb begin
        gnt = '0;
        vld = |rq;
        if (rq[RQ_CHAN]) begin
            gnt[RQ_CHAN] = 1'b1;
        end else if (rq[RQ_WB]) begin
            gnt[RQ_WB] = 1'b1;
        end else if (rq[RQ_EBOX]) begin
            gnt[RQ_EBOX] = 1'b1;
        end
    end

endmodule

// File: rtl/mbc_mem_cyc_sched.sv
// MBox memory-cycle scheduler: arbitrates channel, writeback and EBOX refill
// requests and sequences one SBus cycle through ACKN and the data-valid words.
module mbc_mem_cyc_sched
    import mbc_pkg::*;
#(
    parameter int ACK_TMO = 255,
    parameter int DV_TMO  = 255
) (
    input  logic       clk1_mbc_h,
    input  logic       mr_reset_l,
    input  logic       chan_rq_h,
    input  logic       wb_rq_h,
    input  logic       ebox_rq_h,
    input  logic       chan_wr_h,
    input  logic [3:0] chan_rq_mask_h,
    input  logic [3:0] wb_rq_mask_h,
    input  logic [3:0] ebox_rq_mask_h,
    input  logic [1:0] chan_adr_34_35_h,
    input  logic [1:0] wb_adr_34_35_h,
    input  logic [1:0] ebox_adr_34_35_h,
    input  logic       mem_ackn_h,
    input  logic       mem_data_valid_l,
    output logic       chan_gnt_h,
    output logic       wb_gnt_h,
    output logic       ebox_gnt_h,
    output logic       chan_done_h,
    output logic       wb_done_h,
    output logic       ebox_done_h,
    output logic       mem_start_h,
    output logic       mem_rd_rq_h,
    output logic       mem_wr_rq_h,
    output logic [3:0] mem_rq_h,
    output logic [1:0] core_adr_34_35_h,
    output logic       core_busy_h,
    output logic       core_data_valid_h,
    output logic       nxm_err_h
);

    mbc_cyc_state_t    state, state_nxt;
    logic [NUM_RQ-1:0] gnt_q, prio_gnt;
    logic              prio_vld;
    logic [3:0]        sel_mask;
    logic [1:0]        sel_adr;
    logic              sel_wr;
    logic [2:0]        word_cnt;
    logic [7:0]        tmo_cnt;
    logic              load_cyc, load_cnt, take_word, set_nxm, tmo_clr;
    logic              strobe;

    assign strobe = ~mem_data_valid_l;

    mbc_rq_prio u_prio (
        .rq  ({ebox_rq_h, wb_rq_h, chan_rq_h}),
        .gnt (prio_gnt),
        .vld (prio_vld)
    );

    assign chan_gnt_h  = gnt_q[RQ_CHAN];
    assign wb_gnt_h    = gnt_q[RQ_WB];
    assign ebox_gnt_h  = gnt_q[RQ_EBOX];
    assign chan_done_h = gnt_q[RQ_CHAN] && (state == ST_DONE);
    assign wb_done_h   = gnt_q[RQ_WB]   && (state == ST_DONE);
    assign ebox_done_h = gnt_q[RQ_EBOX] && (state == ST_DONE);
    assign mem_start_h = (state == ST_START);
    assign core_busy_h = (state != ST_IDLE);

    // Steer the winning requester's mask, first word and cycle type.
    always_comb begin
        sel_mask = ebox_rq_mask_h;
        sel_adr  = ebox_adr_34_35_h;
        sel_wr   = 1'b0;
        if (prio_gnt[RQ_CHAN]) begin
            sel_mask = chan_rq_mask_h;
            sel_adr  = chan_adr_34_35_h;
            sel_wr   = chan_wr_h;
        end else if (prio_gnt[RQ_WB]) begin
            sel_mask = wb_rq_mask_h;
            sel_adr  = wb_adr_34_35_h;
            sel_wr   = 1'b1;
        end
    end

    // Cycle sequencing: next state plus the one-cycle control strobes.
    always_comb begin
        state_nxt = state;
        load_cyc  = 1'b0;
        load_cnt  = 1'b0;
        take_word = 1'b0;
        set_nxm   = 1'b0;
        tmo_clr   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (prio_vld) begin
                    load_cyc  = 1'b1;
                    state_nxt = (sel_mask == 4'b0000) ? ST_DONE : ST_START;
                end
            end
            ST_START: state_nxt = ST_WAIT_ACK;
            ST_WAIT_ACK: begin
                if (mem_ackn_h) begin
                    load_cnt  = 1'b1;
                    state_nxt = ST_DATA;
                end else if (tmo_cnt == 8'(ACK_TMO - 1)) begin
                    set_nxm   = 1'b1;
                    state_nxt = ST_DONE;
                end
            end
            ST_DATA: begin
                if (strobe) begin
                    take_word = 1'b1;
                    tmo_clr   = 1'b1;
                    if (word_cnt <= 3'd1) begin
                        state_nxt = ST_DONE;
                    end
                end else if (tmo_cnt == 8'(DV_TMO - 1)) begin
                    set_nxm   = 1'b1;
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk1_mbc_h or negedge mr_reset_l) begin
        if (!mr_reset_l) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Grant and cycle-type registers: latched at arbitration, dropped in DONE.
    always_ff @(posedge clk1_mbc_h or negedge mr_reset_l) begin
        if (!mr_reset_l) begin
            gnt_q       <= '0;
            mem_rq_h    <= 4'b0000;
            mem_rd_rq_h <= 1'b0;
            mem_wr_rq_h <= 1'b0;
        end else if (load_cyc) begin
            gnt_q       <= prio_gnt;
            mem_rq_h    <= sel_mask;
            mem_rd_rq_h <= ~sel_wr;
            mem_wr_rq_h <= sel_wr;
        end else if (state == ST_DONE) begin
            gnt_q       <= '0;
            mem_rq_h    <= 4'b0000;
            mem_rd_rq_h <= 1'b0;
            mem_wr_rq_h <= 1'b0;
        end
    end

    // Word tracking: first word at or after the start address, then the next
    // set mask bit on every accepted strobe, alongside the registered strobe.
    always_ff @(posedge clk1_mbc_h or negedge mr_reset_l) begin
        if (!mr_reset_l) begin
            core_adr_34_35_h  <= 2'd0;
            word_cnt          <= 3'd0;
            core_data_valid_h <= 1'b0;
        end else begin
            core_data_valid_h <= take_word;
            if (load_cyc) begin
                core_adr_34_35_h <= (sel_mask == 4'b0000) ? sel_adr
                                                          : next_word(sel_mask, sel_adr - 2'd1);
            end else if (take_word) begin
                core_adr_34_35_h <= next_word(mem_rq_h, core_adr_34_35_h);
            end
            if (load_cnt) begin
                word_cnt <= bit_count(mem_rq_h);
            end else if (take_word) begin
                word_cnt <= word_cnt - 3'd1;
            end
        end
    end

    // Shared ACKN / data-valid timeout and the sticky non-existent-memory flag.
    always_ff @(posedge clk1_mbc_h or negedge mr_reset_l) begin
        if (!mr_reset_l) begin
            tmo_cnt   <= 8'd0;
            nxm_err_h <= 1'b0;
        end else begin
            if (tmo_clr || (state_nxt != state)) begin
                tmo_cnt <= 8'd0;
            end else begin
                tmo_cnt <= tmo_cnt + 8'd1;
            end
            if (set_nxm) begin
                nxm_err_h <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mbc_mem_cyc_sched.sv
// Scoreboard testbench for the MBC memory-cycle scheduler.
module tb_mbc_mem_cyc_sched;

    logic       clk1_mbc_h = 1'b0;
    logic       mr_reset_l;
    logic       chan_rq_h, wb_rq_h, ebox_rq_h, chan_wr_h;
    logic [3:0] chan_rq_mask_h, wb_rq_mask_h, ebox_rq_mask_h;
    logic [1:0] chan_adr_34_35_h, wb_adr_34_35_h, ebox_adr_34_35_h;
    logic       mem_ackn_h, mem_data_valid_l;
    logic       chan_gnt_h, wb_gnt_h, ebox_gnt_h;
    logic       chan_done_h, wb_done_h, ebox_done_h;
    logic       mem_start_h, mem_rd_rq_h, mem_wr_rq_h;
    logic [3:0] mem_rq_h;
    logic [1:0] core_adr_34_35_h;
    logic       core_busy_h, core_data_valid_h, nxm_err_h;

    always #5 clk1_mbc_h = ~clk1_mbc_h;

    mbc_mem_cyc_sched #(.ACK_TMO(255), .DV_TMO(255)) dut (
        .clk1_mbc_h        (clk1_mbc_h),
        .mr_reset_l        (mr_reset_l),
        .chan_rq_h         (chan_rq_h),
        .wb_rq_h           (wb_rq_h),
        .ebox_rq_h         (ebox_rq_h),
        .chan_wr_h         (chan_wr_h),
        .chan_rq_mask_h    (chan_rq_mask_h),
        .wb_rq_mask_h      (wb_rq_mask_h),
        .ebox_rq_mask_h    (ebox_rq_mask_h),
        .chan_adr_34_35_h  (chan_adr_34_35_h),
        .wb_adr_34_35_h    (wb_adr_34_35_h),
        .ebox_adr_34_35_h  (ebox_adr_34_35_h),
        .mem_ackn_h        (mem_ackn_h),
        .mem_data_valid_l  (mem_data_valid_l),
        .chan_gnt_h        (chan_gnt_h),
        .wb_gnt_h          (wb_gnt_h),
        .ebox_gnt_h        (ebox_gnt_h),
        .chan_done_h       (chan_done_h),
        .wb_done_h         (wb_done_h),
        .ebox_done_h       (ebox_done_h),
        .mem_start_h       (mem_start_h),
        .mem_rd_rq_h       (mem_rd_rq_h),
        .mem_wr_rq_h       (mem_wr_rq_h),
        .mem_rq_h          (mem_rq_h),
        .core_adr_34_35_h  (core_adr_34_35_h),
        .core_busy_h       (core_busy_h),
        .core_data_valid_h (core_data_valid_h),
        .nxm_err_h         (nxm_err_h)
    );

    typedef struct {
        logic [2:0] gnt;
        logic       rd;
        logic       wr;
        logic [3:0] mask;
        logic       start;
    } gnt_exp_t;

    typedef struct {
        logic [2:0] done;
        logic       nxm;
        logic       with_dv;
    } done_exp_t;

    gnt_exp_t  gnt_q[$];
    logic [1:0] word_q[$];
    done_exp_t done_q[$];
    int checks = 0;
    int errors = 0;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic push_grant(input logic [2:0] g, input logic rd, input logic wr,
                              input logic [3:0] m, input logic st);
        gnt_exp_t e;
        e.gnt = g; e.rd = rd; e.wr = wr; e.mask = m; e.start = st;
        gnt_q.push_back(e);
    endtask

    task automatic push_done(input logic [2:0] d, input logic nxm, input logic with_dv);
        done_exp_t e;
        e.done = d; e.nxm = nxm; e.with_dv = with_dv;
        done_q.push_back(e);
    endtask

    // Monitor: compares grants, transferred words and done pulses as they appear.
    initial begin
        logic [1:0] prev_adr;
        logic       prev_busy;
        logic       prev_gnt_any;
        logic [2:0] gv, dv;
        gnt_exp_t   ge;
        done_exp_t  de;
        logic [1:0] we;
        prev_adr = 2'd0;
        prev_busy = 1'b0;
        prev_gnt_any = 1'b0;
        forever begin
            @(negedge clk1_mbc_h);
            gv = {ebox_gnt_h, wb_gnt_h, chan_gnt_h};
            dv = {ebox_done_h, wb_done_h, chan_done_h};
            if ((gv != 3'b000) && !prev_gnt_any) begin
                if (gnt_q.size() == 0) begin
                    checkOutput("unexpected_grant", int'(gv), 0);
                end else begin
                    ge = gnt_q.pop_front();
                    checkOutput("grant_vector", int'(gv), int'(ge.gnt));
                    checkOutput("mem_rd_rq", int'(mem_rd_rq_h), int'(ge.rd));
                    checkOutput("mem_wr_rq", int'(mem_wr_rq_h), int'(ge.wr));
                    checkOutput("mem_rq_mask", int'(mem_rq_h), int'(ge.mask));
                    checkOutput("start_with_grant", int'(mem_start_h), int'(ge.start));
                    checkOutput("idle_gap_before_grant", int'(prev_busy), 0);
                end
            end
            if (core_data_valid_h) begin
                if (word_q.size() == 0) begin
                    checkOutput("unexpected_data_valid", 1, 0);
                end else begin
                    we = word_q.pop_front();
                    checkOutput("word_adr", int'(prev_adr), int'(we));
                end
            end
            if (dv != 3'b000) begin
                if (done_q.size() == 0) begin
                    checkOutput("unexpected_done", int'(dv), 0);
                end else begin
                    de = done_q.pop_front();
                    checkOutput("done_vector", int'(dv), int'(de.done));
                    checkOutput("nxm_at_done", int'(nxm_err_h), int'(de.nxm));
                    checkOutput("done_after_last_strobe", int'(core_data_valid_h), int'(de.with_dv));
                end
            end
            prev_adr = core_adr_34_35_h;
            prev_busy = core_busy_h;
            prev_gnt_any = (gv != 3'b000);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk1_mbc_h);
    endtask

    task automatic wait_start(input string name);
        int n;
        n = 0;
        while (!mem_start_h && n < 50) begin
            tick(1);
            n++;
        end
        checkOutput({name, "_start_seen"}, int'(mem_start_h), 1);
    endtask

    task automatic ack_after(input int delay);
        tick(delay);
        mem_ackn_h = 1'b1;
        tick(1);
        mem_ackn_h = 1'b0;
    endtask

    task automatic strobe_run(input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            mem_data_valid_l = 1'b0;
            tick(1);
            mem_data_valid_l = 1'b1;
            if (i != n - 1) tick(gap);
        end
    endtask

    task automatic wait_done(input string name, input int limit, output int waited);
        waited = 0;
        while (!(chan_done_h || wb_done_h || ebox_done_h) && waited < limit) begin
            tick(1);
            waited++;
        end
        checkOutput({name, "_done_seen"}, int'(chan_done_h || wb_done_h || ebox_done_h), 1);
        if (chan_done_h || waited >= limit) chan_rq_h = 1'b0;
        if (wb_done_h   || waited >= limit) wb_rq_h   = 1'b0;
        if (ebox_done_h || waited >= limit) ebox_rq_h = 1'b0;
    endtask

    task automatic check_reset_values(input string name);
        checkOutput({name, "_grants"}, int'({ebox_gnt_h, wb_gnt_h, chan_gnt_h}), 0);
        checkOutput({name, "_dones"}, int'({ebox_done_h, wb_done_h, chan_done_h}), 0);
        checkOutput({name, "_start"}, int'(mem_start_h), 0);
        checkOutput({name, "_rd_wr"}, int'({mem_rd_rq_h, mem_wr_rq_h}), 0);
        checkOutput({name, "_mem_rq"}, int'(mem_rq_h), 0);
        checkOutput({name, "_core_adr"}, int'(core_adr_34_35_h), 0);
        checkOutput({name, "_busy"}, int'(core_busy_h), 0);
        checkOutput({name, "_data_valid"}, int'(core_data_valid_h), 0);
        checkOutput({name, "_nxm"}, int'(nxm_err_h), 0);
    endtask

    // Directed stimulus; expected responses are queued before each request.
    task automatic applyStimulus();
        int waited;

        // Single-word EBOX read, ACKN after 3 cycles, stray strobe in WAIT_ACK.
        push_grant(3'b100, 1'b1, 1'b0, 4'b0001, 1'b1);
        word_q.push_back(2'd0);
        push_done(3'b100, 1'b0, 1'b1);
        ebox_rq_mask_h = 4'b0001; ebox_adr_34_35_h = 2'd0; ebox_rq_h = 1'b1;
        wait_start("single");
        tick(1);
        mem_data_valid_l = 1'b0;
        tick(1);
        mem_data_valid_l = 1'b1;
        ack_after(1);
        strobe_run(1, 0);
        wait_done("single", 20, waited);
        tick(2);

        // Channel read quad starting at word 2, ACKN pulsed during START first.
        push_grant(3'b001, 1'b1, 1'b0, 4'b1111, 1'b1);
        word_q.push_back(2'd2); word_q.push_back(2'd3);
        word_q.push_back(2'd0); word_q.push_back(2'd1);
        push_done(3'b001, 1'b0, 1'b1);
        chan_wr_h = 1'b0; chan_rq_mask_h = 4'b1111; chan_adr_34_35_h = 2'd2; chan_rq_h = 1'b1;
        wait_start("quad");
        mem_ackn_h = 1'b1;
        tick(1);
        mem_ackn_h = 1'b0;
        ack_after(2);
        strobe_run(4, 1);
        wait_done("quad", 20, waited);
        tick(2);

        // Sparse writeback write, with one surplus strobe held into DONE.
        push_grant(3'b010, 1'b0, 1'b1, 4'b1010, 1'b1);
        word_q.push_back(2'd1); word_q.push_back(2'd3);
        push_done(3'b010, 1'b0, 1'b1);
        wb_rq_mask_h = 4'b1010; wb_adr_34_35_h = 2'd0; wb_rq_h = 1'b1;
        wait_start("sparse");
        ack_after(1);
        mem_data_valid_l = 1'b0;
        tick(2);
        wait_done("sparse", 20, waited);
        tick(1);
        mem_data_valid_l = 1'b1;
        tick(2);

        // All three requesters at once; chan start address not in its mask.
        push_grant(3'b001, 1'b1, 1'b0, 4'b0001, 1'b1);
        push_grant(3'b010, 1'b0, 1'b1, 4'b0100, 1'b1);
        push_grant(3'b100, 1'b1, 1'b0, 4'b1000, 1'b1);
        word_q.push_back(2'd0); word_q.push_back(2'd2); word_q.push_back(2'd3);
        push_done(3'b001, 1'b0, 1'b1);
        push_done(3'b010, 1'b0, 1'b1);
        push_done(3'b100, 1'b0, 1'b1);
        chan_wr_h = 1'b0; chan_rq_mask_h = 4'b0001; chan_adr_34_35_h = 2'd1;
        wb_rq_mask_h = 4'b0100; wb_adr_34_35_h = 2'd2;
        ebox_rq_mask_h = 4'b1000; ebox_adr_34_35_h = 2'd3;
        chan_rq_h = 1'b1; wb_rq_h = 1'b1; ebox_rq_h = 1'b1;
        for (int k = 0; k < 3; k++) begin
            wait_start("conflict");
            ack_after(1);
            strobe_run(1, 0);
            wait_done("conflict", 20, waited);
        end
        tick(2);

        // Empty mask: granted, straight to DONE, never started.
        push_grant(3'b001, 1'b0, 1'b1, 4'b0000, 1'b0);
        push_done(3'b001, 1'b0, 1'b0);
        chan_wr_h = 1'b1; chan_rq_mask_h = 4'b0000; chan_adr_34_35_h = 2'd1; chan_rq_h = 1'b1;
        wait_done("empty_mask", 10, waited);
        tick(2);

        // No ACKN: NXM after 255 WAIT_ACK cycles, DONE on the 256th cycle after START.
        push_grant(3'b100, 1'b1, 1'b0, 4'b0001, 1'b1);
        push_done(3'b100, 1'b1, 1'b0);
        ebox_rq_mask_h = 4'b0001; ebox_adr_34_35_h = 2'd0; ebox_rq_h = 1'b1;
        wait_start("nxm_ack");
        wait_done("nxm_ack", 300, waited);
        checkOutput("nxm_ack_latency", waited, 256);
        tick(2);

        // Strobes stop midway through DATA: NXM 255 cycles after the last strobe.
        push_grant(3'b010, 1'b0, 1'b1, 4'b0011, 1'b1);
        word_q.push_back(2'd0);
        push_done(3'b010, 1'b1, 1'b0);
        wb_rq_mask_h = 4'b0011; wb_adr_34_35_h = 2'd0; wb_rq_h = 1'b1;
        wait_start("nxm_data");
        ack_after(1);
        strobe_run(1, 0);
        wait_done("nxm_data", 400, waited);
        checkOutput("nxm_data_latency", waited, 255);
        tick(2);

        // Asynchronous reset in the middle of DATA: no done pulse may follow.
        push_grant(3'b001, 1'b1, 1'b0, 4'b1111, 1'b1);
        word_q.push_back(2'd0); word_q.push_back(2'd1);
        chan_wr_h = 1'b0; chan_rq_mask_h = 4'b1111; chan_adr_34_35_h = 2'd0; chan_rq_h = 1'b1;
        wait_start("mid_reset");
        ack_after(1);
        strobe_run(2, 0);
        #2;
        mr_reset_l = 1'b0;
        #1;
        check_reset_values("mid_reset");
        chan_rq_h = 1'b0;
        tick(3);
        mr_reset_l = 1'b1;
        tick(6);
        checkOutput("after_reset_busy", int'(core_busy_h), 0);
    endtask

    initial begin
        mr_reset_l = 1'b1;
        chan_rq_h = 1'b0; wb_rq_h = 1'b0; ebox_rq_h = 1'b0; chan_wr_h = 1'b0;
        chan_rq_mask_h = 4'b0000; wb_rq_mask_h = 4'b0000; ebox_rq_mask_h = 4'b0000;
        chan_adr_34_35_h = 2'd0; wb_adr_34_35_h = 2'd0; ebox_adr_34_35_h = 2'd0;
        mem_ackn_h = 1'b0; mem_data_valid_l = 1'b1;
        #1;
        mr_reset_l = 1'b0;
        #1;
        check_reset_values("reset");
        tick(2);
        mr_reset_l = 1'b1;
        tick(2);
        applyStimulus();
        checkOutput("grant_queue_drained", gnt_q.size(), 0);
        checkOutput("word_queue_drained", word_q.size(), 0);
        checkOutput("done_queue_drained", done_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mbc_mem_cyc_sched.md
# mbc_mem_cyc_sched

Memory-cycle scheduler for the MBox MB/core interface. It arbitrates core-memory requests from the channel, cache writeback and EBOX-refill paths, launches one SBus cycle at a time, and sequences the cycle through ACKN and the data-valid words. It also drives the word-in-quad address and the core-busy status that the MBC datapath uses to steer data into and out of the cache.

## Interface
Parameters:
- ACK_TMO, 255: cycles in WAIT_ACK without ACKN before NXM is declared.
- DV_TMO, 255: cycles in DATA without a data-valid strobe before NXM is declared.

Ports:
- clk1_mbc_h  in  1  MBC clock; all state changes on the rising edge.
- mr_reset_l  in  1  reset, asynchronous assert, active-low.
- chan_rq_h, wb_rq_h, ebox_rq_h  in  1 each  level requests; each is held until its done pulse.
- chan_wr_h  in  1  channel cycle is a write (0 = read).
- chan_rq_mask_h, wb_rq_mask_h, ebox_rq_mask_h  in  4 each  words of the quad requested; bit 0 = word 0.
- chan_adr_34_35_h, wb_adr_34_35_h, ebox_adr_34_35_h  in  2 each  first word of the quad.
- mem_ackn_h  in  1  SBus acknowledge.
- mem_data_valid_l  in  1  one word strobe per low cycle.
- chan_gnt_h, wb_gnt_h, ebox_gnt_h  out  1 each  one-hot; high from START through DONE.
- chan_done_h, wb_done_h, ebox_done_h  out  1 each  one-cycle pulse in DONE.
- mem_start_h  out  1  one-cycle start pulse.
- mem_rd_rq_h, mem_wr_rq_h  out  1 each  cycle type, held for the whole cycle.
- mem_rq_h  out  4  latched word mask, held for the whole cycle.
- core_adr_34_35_h  out  2  word currently being transferred.
- core_busy_h  out  1  high in every state except IDLE.
- core_data_valid_h  out  1  registered copy of the data-valid strobe, gated to the DATA state.
- nxm_err_h  out  1  sticky flag; cleared by reset only.

## Operation
- States: IDLE, START, WAIT_ACK, DATA, DONE.
- IDLE:
  - Sample the requests. Priority is fixed: chan > wb > ebox.
  - The winner's mask and address are latched into the mask, address and type registers.
  - The cycle type is: write for wb; chan_wr_h for chan; read for ebox.
  - A request with an all-zero mask is granted. It goes straight to DONE with no start.
  - Otherwise go to START.
- START: mem_start_h = 1 for one cycle, then go to WAIT_ACK.
- WAIT_ACK:
  - On mem_ackn_h, go to DATA and load the remaining-word count = popcount(mask).
  - If ACK_TMO cycles pass with no ACKN, set nxm_err_h and go to DONE.
- DATA:
  - Each cycle with mem_data_valid_l = 0 transfers one word:
    - pulse core_data_valid_h;
    - decrement the count;
    - advance core_adr_34_35_h to the next set mask bit, modulo 4, wrapping 3→0.
  - The strobe that brings the count to 0 moves the block to DONE.
  - If DV_TMO cycles pass with no strobe, set nxm_err_h and go to DONE.
- DONE:
  - Pulse the granted requester's done output.
  - Drop the grant, the type and mem_rq_h, then return to IDLE.
- Boundary cases:
  - Word address: if the start address is not in the mask, core_adr_34_35_h advances to the first set bit at or after it, wrapping.
  - Simultaneous requests: only the highest priority is granted. The others wait, and the order is re-evaluated in IDLE.
  - ACKN arriving in START is ignored.
  - A data-valid strobe in WAIT_ACK is ignored.
  - Extra strobes after the count reaches 0 are ignored.
  - A requester dropping its request mid-cycle does not abort the cycle.
- Reset values (async, reset low):
  - state = IDLE;
  - all grant, done and start outputs = 0; mem_rd_rq_h = mem_wr_rq_h = 0;
  - mem_rq_h = 0, core_adr_34_35_h = 0, count = 0, core_busy_h = 0, core_data_valid_h = 0, nxm_err_h = 0.
- Reset mid-cycle: the cycle is abandoned with no done pulse, and the requester re-requests after reset.

## Timing
- IDLE→START takes one cycle. The grant rises on the same edge as the START entry, and mem_start_h is high in the following cycle.
- Minimum full cycle for a 1-word request with ACKN on the first WAIT_ACK cycle is 5 clocks: IDLE, START, WAIT_ACK, DATA, DONE.
- The done pulse occurs exactly one cycle after the last data strobe. The next grant can come no earlier than the cycle after DONE.
- core_data_valid_h lags mem_data_valid_l by one cycle. core_adr_34_35_h changes on the same edge as core_data_valid_h.

## Structure
- mbc_pkg holds:
  - the state enum typedef (mbc_cyc_state_t);
  - the requester index constants (RQ_CHAN=0, RQ_WB=1, RQ_EBOX=2);
  - the function next_word(mask, adr), which returns the next set bit modulo 4.
- One sub-module, mbc_rq_prio: a 3-input fixed-priority encoder that outputs a one-hot grant and a valid bit.
- The timeout counter is shared between WAIT_ACK and DATA. It is 8 bits wide and clears on every state change.

## Test plan
- Single-word read: ebox_rq with mask 0001, adr 0; ACKN after 3 cycles, one strobe → mem_rd_rq_h=1, mem_rq_h=0001, core_adr_34_35_h=0, one core_data_valid_h pulse, ebox_done pulse, nxm_err_h=0.
- Quad with wrap: chan read, mask 1111, adr 2 → core_adr_34_35_h sequence 2,3,0,1; done after the 4th strobe.
- Conflict: chan, wb and ebox all raised in the same cycle → grants go chan, then wb, then ebox. Each grant is one-hot and core_busy_h drops for one IDLE cycle between them.
- Sparse mask: wb write, mask 1010, adr 0 → mem_wr_rq_h=1, word sequence 1,3, done after 2 strobes.
- NXM: ebox request with no ACKN for 255 cycles → nxm_err_h=1 and ebox_done pulses. A second case stops strobes midway through DATA → the same result.
- Reset mid-DATA: drop mr_reset_l asynchronously → all outputs are at their reset values immediately and no done pulse occurs.
